// File: rtl/pc_gen.sv
// Program-counter generator: holds the fetch PC, picks the next PC from
// sequential/redirect/trap/mret sources, saves the exception PC and counts retires.
module pc_gen #(
    parameter int                 XLEN         = 32,
    parameter logic [XLEN-1:0]    RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]    TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int                 IALIGN       = 4,
    parameter int                 CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap,
    input  logic             mret,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic [XLEN-1:0]  epc,
    output logic             fetch_valid,
    output logic             in_trap,
    output logic [1:0]       cause,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t state;
    logic   misaligned;
    logic   bad_redirect;
    logic   retire_en;

    always_comb begin
        misaligned = 1'b0;
        if (IALIGN == 2)
            misaligned = redirect_target[0];
        else
            misaligned = |redirect_target[1:0];
    end

    assign pc_plus4     = pc + PC_STEP;
    assign bad_redirect = redirect_valid && misaligned;
    // fetch_valid is only high in RUN/TRAP, so BOOT never retires.
    assign retire_en    = fetch_valid && !stall && !trap && !bad_redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= BOOT;
            pc           <= RESET_VECTOR;
            epc          <= '0;
            fetch_valid  <= 1'b0;
            in_trap      <= 1'b0;
            cause        <= 2'd0;
            retire_count <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                    in_trap     <= 1'b0;
                    cause       <= 2'd0;
                end
                RUN, TRAP: begin
                    if (trap || (bad_redirect && !stall)) begin
                        pc      <= TRAP_VECTOR;
                        cause   <= trap ? 2'd1 : 2'd2;
                        // A nested trap keeps the epc of the original fault.
                        if (state == RUN)
                            epc <= pc;
                        state   <= TRAP;
                        in_trap <= 1'b1;
                    end else if (!stall) begin
                        cause <= 2'd0;
                        if (state == TRAP && mret) begin
                            pc      <= epc;
                            state   <= RUN;
                            in_trap <= 1'b0;
                        end else if (redirect_valid) begin
                            pc <= redirect_target;
                        end else begin
                            pc <= pc_plus4;
                        end
                    end
                    if (retire_en)
                        retire_count <= retire_count + CNT_W'(1);
                end
                default: begin
                    state       <= BOOT;
                    fetch_valid <= 1'b0;
                    in_trap     <= 1'b0;
                    cause       <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the single-cycle RISC-V core; the successor to the plain PC register.
- Holds the fetch PC and selects the next PC from sequential, redirect (branch/jump), trap-entry and trap-return sources.
- Supports a stall input, detects misaligned targets, saves the exception PC, and counts retired instructions.
- Sits between the next-PC mux/branch unit and the instruction memory address port.

Parameters:
- XLEN, 32, PC/address width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry.
- IALIGN, 4, instruction alignment in bytes (legal values 2 or 4).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold PC this cycle; no retire
- redirect_valid  input  1  take redirect_target as next PC
- redirect_target  input  XLEN  branch/jump target
- trap  input  1  current instruction traps (external/illegal/ecall)
- mret  input  1  return from trap handler
- pc  output  XLEN  current fetch PC
- pc_plus4  output  XLEN  pc + 4, combinational
- epc  output  XLEN  saved exception PC
- fetch_valid  output  1  pc is a valid fetch address
- in_trap  output  1  core is executing the trap handler
- cause  output  2  0 none, 1 trap input, 2 misaligned redirect; registered, valid for one cycle after trap entry
- retire_count  output  CNT_W  retired-instruction counter

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous and active-high; it is sampled only at the clk edge.
- Reset values: pc=RESET_VECTOR, epc=0, fetch_valid=0, in_trap=0, cause=0, retire_count=0, state=BOOT.
- Reset has top priority over every other input.
- States:
  - BOOT: exactly one cycle after reset deasserts. pc held, fetch_valid=0, all inputs ignored. Next state RUN.
  - RUN: normal execution, fetch_valid=1, in_trap=0.
  - TRAP: executing the handler, fetch_valid=1, in_trap=1.
- Misalignment: redirect_target is misaligned if bits[1:0]!=0 when IALIGN=4, or bit[0]!=0 when IALIGN=2.
- Next-PC priority in RUN/TRAP, highest first:
  1. trap: pc<=TRAP_VECTOR, cause<=1, state<=TRAP.
  2. redirect_valid && misaligned && !stall: pc<=TRAP_VECTOR, cause<=2, state<=TRAP.
  3. stall: pc, epc, state and counter all hold.
  4. mret in TRAP: pc<=epc, state<=RUN.
  5. redirect_valid: pc<=redirect_target.
  6. otherwise: pc<=pc+4.
- epc on trap entry:
  - Entering TRAP from RUN: epc<=pc (the faulting instruction).
  - Trap while already in TRAP: pc<=TRAP_VECTOR, epc unchanged (the original epc is kept).
- trap overrides stall. A stalled redirect or mret is dropped and must be re-presented by the core.
- mret in RUN is ignored and falls through to redirect/sequential.
- mret and redirect_valid in the same TRAP cycle: mret wins.
- cause returns to 0 on the next non-trap-entry, non-stalled cycle; a stall holds it.
- retire_count increments by 1 on each cycle where fetch_valid && !stall && !trap && !(redirect misaligned). It wraps modulo 2^CNT_W without a flag.
- pc and pc_plus4 arithmetic is modulo 2^XLEN. For example, 32'hFFFF_FFFC + 4 = 0.
- Reset asserted mid-TRAP or mid-stall: the next edge returns to the reset values and state BOOT.

Test Plan:
- Reset asserted, then released.
  - One cycle: pc=0, fetch_valid=0 (BOOT).
  - Next cycle: fetch_valid=1; subsequent edges give pc=4, then 8; retire_count=2 after those two edges.
- pc=8, stall=1 for 3 cycles, then redirect_valid=1, target=32'h40.
  - pc stays 8 and count stays unchanged during the stall.
  - Next edge: pc=32'h40.
- pc=32'h40, trap=1.
  - pc=32'h100, epc=32'h40, cause=1, in_trap=1.
  - One cycle later cause=0, with no retire on the trap cycle.
  - A second trap at pc=32'h104 gives pc=32'h100 and epc still 32'h40.
- In TRAP, mret=1 together with redirect_valid=1, target=32'h200.
  - Result: pc=32'h40, in_trap=0.
  - mret=1 in RUN at pc=32'h40: result pc=32'h44.
- IALIGN=4, redirect_target=32'h0000_0042 at pc=32'h10.
  - Result: pc=32'h100, epc=32'h10, cause=2, count unchanged.
  - With IALIGN=2 and the same target: pc=32'h42.
- CNT_W=4, run 16 retiring cycles: retire_count wraps to 0.
  - Run from pc=32'hFFFF_FFFC: next pc=0.
  - Reset during TRAP: pc=0, in_trap=0, epc=0.
